// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers, run-counter width, command bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    PORT_CORE,
    PORT_DMA
  } port_e;

  // Width of the consecutive-DMA-grant counter; bounds MAX_BURST to 1..15.
  localparam int DMEM_ARB_RUN_W = 4;

  // Data-path width of every address and data bus around the arbiter.
  localparam int DMEM_ARB_DW = 32;

  // One memory command as presented by a requester or driven to the memory.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ARB_DW-1:0] addr;
    logic [DMEM_ARB_DW-1:0] wd;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, response and memory-side signals around the data-memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the requester until the matching grant.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  // Core load/store port
  logic                   core_req_i;
  logic                   core_we_i;
  logic [DMEM_ARB_DW-1:0] core_addr_i;
  logic [DMEM_ARB_DW-1:0] core_wd_i;
  logic                   core_gnt_o;
  logic                   core_rvalid_o;
  logic [DMEM_ARB_DW-1:0] core_rd_o;

  // DMA port
  logic                   dma_req_i;
  logic                   dma_we_i;
  logic [DMEM_ARB_DW-1:0] dma_addr_i;
  logic [DMEM_ARB_DW-1:0] dma_wd_i;
  logic                   dma_gnt_o;
  logic                   dma_rvalid_o;
  logic [DMEM_ARB_DW-1:0] dma_rd_o;

  // Single-port data memory
  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [DMEM_ARB_DW-1:0] mem_addr_o;
  logic [DMEM_ARB_DW-1:0] mem_wd_o;
  logic [DMEM_ARB_DW-1:0] mem_rd_i;

  // Arbiter view
  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wd_i,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wd_i,
    input  mem_rd_i,
    output core_gnt_o, core_rvalid_o, core_rd_o,
    output dma_gnt_o, dma_rvalid_o, dma_rd_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
  );

  // Requesters-plus-memory view
  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wd_i,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wd_i,
    output mem_rd_i,
    input  core_gnt_o, core_rvalid_o, core_rd_o,
    input  dma_gnt_o, dma_rvalid_o, dma_rd_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
  );

endinterface

// File: rtl/dmem_arb_sel.sv
// Grant selection: round-robin between CORE and DMA, with bounded DMA bursts under contention.
// Latency: grants are combinational from the requests and the registered history (0 cycles).
// Backpressure: a losing requester simply sees no grant and keeps its request up.
module dmem_arb_sel
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4  // legal range 1..15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic core_req,
  input  logic dma_req,
  output logic core_gnt,
  output logic dma_gnt
);

  localparam logic [DMEM_ARB_RUN_W-1:0] BURST_LIM = DMEM_ARB_RUN_W'(MAX_BURST);

  port_e                     last_gnt;
  logic [DMEM_ARB_RUN_W-1:0] dma_run;
  logic                      dma_keeps;

  // DMA may hold the memory only while its burst is live, i.e. it was granted last
  // cycle (dma_run nonzero) and has not yet used its burst allowance. Reset leaves
  // last_gnt = DMA with no live burst, so CORE wins the first contention.
  assign dma_keeps = (last_gnt == PORT_DMA) && (dma_run != '0) && (dma_run < BURST_LIM);

  // Pick at most one winner; nothing is granted while reset is asserted.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst_ni) begin
      if (core_req && dma_req) begin
        if (dma_keeps) begin
          dma_gnt = 1'b1;
        end else if (last_gnt == PORT_DMA) begin
          core_gnt = 1'b1;
        end else begin
          dma_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        dma_gnt  = dma_req;
      end
    end
  end

  // Remember the last owner and count consecutive DMA grants (saturating).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_gnt <= PORT_DMA;
      dma_run  <= '0;
    end else begin
      if (core_gnt) begin
        last_gnt <= PORT_CORE;
      end else if (dma_gnt) begin
        last_gnt <= PORT_DMA;
      end

      if (dma_gnt) begin
        if (dma_run != '1) begin
          dma_run <= dma_run + 1'b1;
        end
      end else begin
        dma_run <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CORE and DMA and steers read data back to the reader.
// Latency: grant and memory command in the request cycle; read data one cycle after the grant.
// Backpressure: one beat per cycle; an ungranted requester holds its request until granted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4  // legal range 1..15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dmem_arbiter_if.slave bus
);

  logic     core_gnt;
  logic     dma_gnt;
  mem_cmd_t core_cmd;
  mem_cmd_t dma_cmd;
  mem_cmd_t mem_cmd;
  logic     rsp_valid;
  port_e    rsp_port;

  dmem_arb_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_sel (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .core_req (bus.core_req_i),
    .dma_req  (bus.dma_req_i),
    .core_gnt (core_gnt),
    .dma_gnt  (dma_gnt)
  );

  assign bus.core_gnt_o = core_gnt;
  assign bus.dma_gnt_o  = dma_gnt;

  // Forward the granted port's command to the memory; all zero when idle.
  always_comb begin
    core_cmd = '{we: bus.core_we_i, addr: bus.core_addr_i, wd: bus.core_wd_i};
    dma_cmd  = '{we: bus.dma_we_i,  addr: bus.dma_addr_i,  wd: bus.dma_wd_i};
    mem_cmd  = '0;
    if (core_gnt) begin
      mem_cmd = core_cmd;
    end else if (dma_gnt) begin
      mem_cmd = dma_cmd;
    end
  end

  assign bus.mem_req_o  = core_gnt | dma_gnt;
  assign bus.mem_we_o   = mem_cmd.we;
  assign bus.mem_addr_o = mem_cmd.addr;
  assign bus.mem_wd_o   = mem_cmd.wd;

  // Track which port owns the read data the memory returns next cycle; writes return nothing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid <= 1'b0;
      rsp_port  <= PORT_CORE;
    end else if (core_gnt && !bus.core_we_i) begin
      rsp_valid <= 1'b1;
      rsp_port  <= PORT_CORE;
    end else if (dma_gnt && !bus.dma_we_i) begin
      rsp_valid <= 1'b1;
      rsp_port  <= PORT_DMA;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  // Steer read data to its owner only; the memory's filler words never leak out.
  always_comb begin
    bus.core_rvalid_o = rsp_valid && (rsp_port == PORT_CORE);
    bus.dma_rvalid_o  = rsp_valid && (rsp_port == PORT_DMA);
    bus.core_rd_o     = bus.core_rvalid_o ? bus.mem_rd_i : '0;
    bus.dma_rd_o      = bus.dma_rvalid_o  ? bus.mem_rd_i : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: memory model, grant reference model, response scoreboard.
// Latency: n/a.
// Backpressure: requests are held until granted, as a real requester would.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int          MAXB   = 4;
  localparam logic [31:0] FILLER = 32'hfa111eaf;
  localparam logic [31:0] OOR    = 32'hdeadbeef;
  localparam logic [31:0] MEM_TOP = 32'h0001_0000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MAX_BURST (MAXB)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Data memory: 64 KiB, registered read, filler on idle/write cycles.
  logic [31:0] dev_mem [0:16383];
  always @(posedge clk_i) begin
    if (bus.mem_req_o && bus.mem_we_o) begin
      if (bus.mem_addr_o < MEM_TOP) dev_mem[bus.mem_addr_o[15:2]] <= bus.mem_wd_o;
      bus.mem_rd_i <= FILLER;
    end else if (bus.mem_req_o) begin
      bus.mem_rd_i <= (bus.mem_addr_o < MEM_TOP) ? dev_mem[bus.mem_addr_o[15:2]] : OOR;
    end else begin
      bus.mem_rd_i <= FILLER;
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:16383];
  // Per-cycle grant history: 0 = idle, 1 = CORE, 2 = DMA (runs of idles collapsed).
  int hist[$];

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t exp_q[$];

  function automatic int dma_streak();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != 2) break;
      n++;
    end
    return n;
  endfunction

  function automatic int last_owner();
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != 0) return hist[i];
    end
    return 2;  // after reset the DMA counts as last owner
  endfunction

  function automatic int exp_winner(input logic c, input logic d);
    int s;
    s = dma_streak();
    if (c && d) begin
      if (s > 0 && s < MAXB) return 2;
      return (last_owner() == 2) ? 1 : 2;
    end
    if (c) return 1;
    if (d) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (a < MEM_TOP) ? ref_mem[a[15:2]] : OOR;
  endfunction

  // Grant and memory-bus checker; records expected read responses.
  always @(negedge clk_i) begin : grant_checker
    int          w;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    if (!rst_ni) begin
      hist.delete();
      chk("rst_grant", 96'({bus.core_gnt_o, bus.dma_gnt_o, bus.mem_req_o}), 96'(0));
      chk("rst_membus", 96'({bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o}), 96'(0));
    end else begin
      w  = exp_winner(bus.core_req_i, bus.dma_req_i);
      we = 1'b0;
      a  = '0;
      d  = '0;
      if (w == 1) begin
        we = bus.core_we_i; a = bus.core_addr_i; d = bus.core_wd_i;
      end else if (w == 2) begin
        we = bus.dma_we_i;  a = bus.dma_addr_i;  d = bus.dma_wd_i;
      end
      chk("grant", 96'({bus.core_gnt_o, bus.dma_gnt_o, bus.mem_req_o}),
          96'({w == 1, w == 2, w != 0}));
      chk("membus", 96'({bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o}), 96'({we, a, d}));
      if (w != 0) begin
        if (we) begin
          if (a < MEM_TOP) ref_mem[a[15:2]] = d;
        end else begin
          exp_q.push_back('{port: w, data: exp_rd(a), due: cyc + 1});
        end
        hist.push_back(w);
      end else if (hist.size() == 0 || hist[hist.size() - 1] != 0) begin
        hist.push_back(0);
      end
      if (hist.size() > 32) void'(hist.pop_front());
    end
  end

  // Response monitor: pops the scoreboard whenever a response is due.
  always @(negedge clk_i) begin : rsp_monitor
    rsp_t       e;
    logic [1:0] vld;
    vld = {bus.core_rvalid_o, bus.dma_rvalid_o};
    chk("rd_zero_when_idle",
        96'({bus.core_rvalid_o ? 32'h0 : bus.core_rd_o, bus.dma_rvalid_o ? 32'h0 : bus.dma_rd_o}),
        96'(0));
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      chk("rsp_late", 96'(exp_q[0].due), 96'(cyc));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rsp", 96'({vld, bus.core_rd_o, bus.dma_rd_o}),
          (e.port == 1) ? 96'({2'b10, e.data, 32'h0}) : 96'({2'b01, 32'h0, e.data}));
    end else begin
      chk("no_rsp", 96'(vld), 96'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
    bus.core_req_i  = req;
    bus.core_we_i   = we;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
    bus.dma_req_i  = req;
    bus.dma_we_i   = we;
    bus.dma_addr_i = addr;
    bus.dma_wd_i   = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(15) == 0) return MEM_TOP + 32'(4 * $urandom_range(63));
    return 32'(4 * $urandom_range(63));
  endfunction

  initial begin : driver
    string seq;
    int    ck;
    int    dk;
    logic  c_pend;
    logic  d_pend;

    // Reset with both ports requesting: nothing may be granted.
    drive_core(1'b1, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b1, 1'b0, 32'h4, 32'h0);
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Constant contention from the first cycle it appears.
    seq = "";
    ck  = 0;
    dk  = 0;
    for (int i = 0; i < 10; i++) begin
      drive_core(1'b1, 1'b1, 32'(32'h100 + 4 * ck), $urandom);
      drive_dma(1'b1, 1'b1, 32'(32'h180 + 4 * dk), $urandom);
      @(negedge clk_i);
      if (bus.core_gnt_o) begin seq = {seq, "C"}; ck++; end
      else if (bus.dma_gnt_o) begin seq = {seq, "D"}; dk++; end
      else seq = {seq, "-"};
      tick();
    end
    n_checks++;
    if (seq != "CDDDDCDDDD") begin
      n_err++;
      $display("FAIL grant_seq: got %s, expected CDDDDCDDDD", seq);
    end
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Fill the working region through the CORE port.
    for (int k = 0; k < 64; k++) begin
      drive_core(1'b1, 1'b1, 32'(4 * k), $urandom);
      tick();
    end

    // Write then read back on the next cycle.
    drive_core(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    tick();
    drive_core(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("write_then_read", 96'({bus.core_rvalid_o, bus.core_rd_o, bus.dma_rvalid_o}),
        96'({1'b1, 32'h1234_5678, 1'b0}));
    tick();

    // Alternating reads, CORE from 0x0 and DMA from 0x4.
    drive_core(1'b1, 1'b1, 32'h0, 32'hA);
    tick();
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b1, 1'b1, 32'h4, 32'hB);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive_core((i % 2 == 0) && (i < 6), 1'b0, 32'h0, 32'h0);
      drive_dma((i % 2 == 1) && (i < 6), 1'b0, 32'h4, 32'h0);
      @(negedge clk_i);
      if (i > 0)
        chk("alt_rsp", 96'({bus.core_rvalid_o, bus.dma_rvalid_o, bus.core_rd_o, bus.dma_rd_o}),
            ((i - 1) % 2 == 0) ? 96'({2'b10, 32'hA, 32'h0}) : 96'({2'b01, 32'h0, 32'hB}));
      tick();
    end

    // Out-of-range DMA read returns the memory's error word.
    drive_dma(1'b1, 1'b0, MEM_TOP, 32'h0);
    tick();
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("oor_read", 96'({bus.dma_rvalid_o, bus.dma_rd_o, bus.core_rd_o}),
        96'({1'b1, OOR, 32'h0}));
    tick();

    // Read granted, then reset asserted before the edge: the response is lost.
    drive_core(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk_i);
    chk("pre_rst_gnt", 96'({bus.core_gnt_o, bus.dma_gnt_o}), 96'(2'b10));
    #1;
    rst_ni = 1'b0;
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.delete();
    tick();
    @(negedge clk_i);
    chk("rst_drops_rvalid", 96'({bus.core_rvalid_o, bus.dma_rvalid_o}), 96'(0));
    tick();
    rst_ni = 1'b1;
    drive_core(1'b1, 1'b0, 32'h20, 32'h0);
    drive_dma(1'b1, 1'b0, 32'h24, 32'h0);
    @(negedge clk_i);
    chk("post_rst_first_win", 96'({bus.core_gnt_o, bus.dma_gnt_o}), 96'(2'b10));
    tick();
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Random traffic; each request is held until granted.
    c_pend = 1'b0;
    d_pend = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!c_pend && $urandom_range(9) < 7) begin
        c_pend = 1'b1;
        drive_core(1'b1, 1'($urandom_range(1)), rand_addr(), $urandom);
      end
      if (!d_pend && $urandom_range(9) < 7) begin
        d_pend = 1'b1;
        drive_dma(1'b1, 1'($urandom_range(1)), rand_addr(), $urandom);
      end
      bus.core_req_i = c_pend;
      bus.dma_req_i  = d_pend;
      @(negedge clk_i);
      if (bus.core_gnt_o) c_pend = 1'b0;
      if (bus.dma_gnt_o)  d_pend = 1'b0;
      tick();
    end

    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    @(negedge clk_i);
    #1;
    chk("drained", 96'(exp_q.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
